// File: rtl/regfile_write_arbiter.sv
// Purpose: arbitrates two writeback requesters (ALU, load) onto one register-file write port.
// Latency: ready is combinational in the request cycle; the write appears on the port one cycle later.
// Backpressure: a lone requester is always accepted; on contention the loser waits, and the stall is counted.
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [ADDR_W-1:0] write_register,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Priority pointer used only on contention: 0 favours A, 1 favours B.
    logic ptr;
    logic a_xfer;
    logic b_xfer;
    logic contend;

    // Grant: a lone requester wins outright; on contention the pointer decides.
    // Nothing is granted while reset is asserted.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            a_ready = a_valid && (!b_valid || !ptr);
            b_ready = b_valid && (!a_valid ||  ptr);
        end
    end

    assign a_xfer  = a_valid && a_ready;
    assign b_xfer  = b_valid && b_ready;
    assign contend = a_valid && b_valid && !rst;

    // Pointer moves to whichever requester lost the most recent transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (a_xfer) begin
            ptr <= 1'b1;
        end else if (b_xfer) begin
            ptr <= 1'b0;
        end
    end

    // Register the granted write; x0 transfers complete the handshake but never write,
    // and the index/data hold whenever no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write      <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
        end else begin
            reg_write <= 1'b0;
            if (a_xfer) begin
                if (a_reg != '0) begin
                    reg_write      <= 1'b1;
                    write_register <= a_reg;
                    write_data     <= a_data;
                end
            end else if (b_xfer) begin
                if (b_reg != '0) begin
                    reg_write      <= 1'b1;
                    write_register <= b_reg;
                    write_data     <= b_data;
                end
            end
        end
    end

    // Saturating count of cycles where one valid requester had to wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (contend && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: self-checking bench for regfile_write_arbiter (default and 4-bit stall counter instances).
// Latency: inputs driven just after the rising edge, outputs sampled on the falling edge.
// Backpressure: random requesters hold valid/reg/data until their handshake completes.
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_reg, b_reg;
    logic [DW-1:0] a_data, b_data;

    logic          a_ready, b_ready, reg_write;
    logic [AW-1:0] write_register;
    logic [DW-1:0] write_data;
    logic [15:0]   stall_count;

    logic          s_a_ready, s_b_ready, s_reg_write;
    logic [AW-1:0] s_write_register;
    logic [DW-1:0] s_write_data;
    logic [3:0]    s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .write_register(write_register), .write_data(write_data),
        .reg_write(reg_write), .stall_count(stall_count)
    );

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(s_b_ready),
        .write_register(s_write_register), .write_data(s_write_data),
        .reg_write(s_reg_write), .stall_count(s_stall_count)
    );

    // Reference model: priority owner, last issued write, and an unbounded stall tally.
    logic          m_prio_b;
    logic          m_we;
    logic [AW-1:0] m_wr;
    logic [DW-1:0] m_wd;
    int            m_stalls;

    typedef struct {
        logic          rst;
        logic          av;
        logic [AW-1:0] ar;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] br;
        logic [DW-1:0] bd;
        logic          ea;
        logic          eb;
        logic          ewe;
        logic [AW-1:0] ewr;
        logic [DW-1:0] ewd;
        int            est;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic row(input logic r, input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                       input logic ea, input logic eb, input logic ewe,
                       input logic [AW-1:0] ewr, input logic [DW-1:0] ewd, input int est);
        vec_t v;
        v.rst = r; v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
        v.ea = ea; v.eb = eb; v.ewe = ewe; v.ewr = ewr; v.ewd = ewd; v.est = est;
        tbl.push_back(v);
    endtask

    // Drive one cycle, check every output against the model at the falling edge, then advance the model.
    task automatic apply(input logic r, input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd);
        logic ga, gb;
        rst = r; a_valid = av; a_reg = ar; a_data = ad; b_valid = bv; b_reg = br; b_data = bd;
        @(negedge clk);
        ga = !r && av && (!bv || !m_prio_b);
        gb = !r && bv && !ga;
        chk("m_a_ready", a_ready, ga);
        chk("m_b_ready", b_ready, gb);
        chk("m_s_a_ready", s_a_ready, ga);
        chk("m_one_grant", a_ready && b_ready, 1'b0);
        chk("m_reg_write", reg_write, m_we);
        chk("m_write_register", write_register, m_wr);
        chk("m_write_data", write_data, m_wd);
        chk("m_stall16", stall_count, sat(m_stalls, 16));
        chk("m_stall4", s_stall_count, sat(m_stalls, 4));
        if (r) begin
            m_prio_b = 1'b0; m_we = 1'b0; m_wr = '0; m_wd = '0; m_stalls = 0;
        end else begin
            if (av && bv) m_stalls++;
            m_we = 1'b0;
            if (ga || gb) begin
                m_prio_b = ga;
                if ((ga ? ar : br) != '0) begin
                    m_we = 1'b1;
                    m_wr = ga ? ar : br;
                    m_wd = ga ? ad : bd;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic          ap, bp;
        logic [AW-1:0] par, pbr;
        logic [DW-1:0] pad, pbd;
        logic          r;

        m_prio_b = 1'b0; m_we = 1'b0; m_wr = '0; m_wd = '0; m_stalls = 0;
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        a_reg = 5'd3; b_reg = 5'd7; a_data = 64'h33; b_data = 64'h77;
        tick();

        //   rst av ar  ad                      bv br  bd       ea eb we wr  wd                      st
        row(1, 1, 3, 64'h33,                 1, 7, 64'h77,  0, 0, 0, 0, 64'h0,                  0);
        row(1, 1, 3, 64'h33,                 1, 7, 64'h77,  0, 0, 0, 0, 64'h0,                  0);
        row(0, 1, 5, 64'h0000_0000_DEAD_BEEF, 0, 0, 64'h0,  1, 0, 0, 0, 64'h0,                  0);
        row(0, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0, 1, 5, 64'h0000_0000_DEAD_BEEF, 0);
        row(0, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0, 0, 5, 64'h0000_0000_DEAD_BEEF, 0);
        row(1, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0, 0, 5, 64'h0000_0000_DEAD_BEEF, 0);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  1, 0, 0, 0, 64'h0,                  0);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  0, 1, 1, 3, 64'h33,                 1);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  1, 0, 1, 7, 64'h77,                 2);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  0, 1, 1, 3, 64'h33,                 3);
        row(0, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0, 1, 7, 64'h77,                 4);
        row(0, 0, 0, 64'h0,                  1, 0, 64'h1,   0, 1, 0, 7, 64'h77,                 4);
        row(0, 1, 9, 64'h99,                 1, 4, 64'h44,  1, 0, 0, 7, 64'h77,                 4);
        row(0, 0, 0, 64'h0,                  1, 4, 64'h44,  0, 1, 1, 9, 64'h99,                 5);
        row(0, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0, 1, 4, 64'h44,                 5);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  1, 0, 0, 4, 64'h44,                 5);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  0, 1, 1, 3, 64'h33,                 6);
        row(1, 1, 3, 64'h33,                 1, 7, 64'h77,  0, 0, 1, 7, 64'h77,                 7);
        row(0, 1, 3, 64'h33,                 1, 7, 64'h77,  1, 0, 0, 0, 64'h0,                  0);
        row(0, 0, 0, 64'h0,                  0, 0, 64'h0,   0, 0, 1, 3, 64'h33,                 1);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].bv, tbl[i].br, tbl[i].bd);
            chk($sformatf("t%0d_a_ready", i), a_ready, tbl[i].ea);
            chk($sformatf("t%0d_b_ready", i), b_ready, tbl[i].eb);
            chk($sformatf("t%0d_reg_write", i), reg_write, tbl[i].ewe);
            chk($sformatf("t%0d_write_register", i), write_register, tbl[i].ewr);
            chk($sformatf("t%0d_write_data", i), write_data, tbl[i].ewd);
            chk($sformatf("t%0d_stall_count", i), stall_count, tbl[i].est);
            tick();
        end

        // Saturation: 20 contention cycles after reset.
        apply(1, 0, 0, 64'h0, 0, 0, 64'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            apply(0, 1, 6, 64'h66, 1, 8, 64'h88);
            tick();
        end
        apply(0, 0, 0, 64'h0, 0, 0, 64'h0);
        chk("sat_stall4", s_stall_count, 4'd15);
        chk("sat_stall16", stall_count, 16'd20);
        tick();

        // Random traffic with protocol-respecting requesters and occasional reset.
        ap = 1'b0; bp = 1'b0; par = '0; pbr = '0; pad = '0; pbd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!ap && ($urandom_range(0, 2) != 0)) begin
                ap = 1'b1; par = AW'($urandom_range(0, 31)); pad = {$urandom, $urandom};
            end
            if (!bp && ($urandom_range(0, 2) != 0)) begin
                bp = 1'b1; pbr = AW'($urandom_range(0, 31)); pbd = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 39) == 0);
            apply(r, ap, par, pad, bp, pbr, pbd);
            if (!r && ap && a_ready) ap = 1'b0;
            if (!r && bp && b_ready) bp = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 64, write data width.
REQ-002 Parameter: ADDR_W, 5, register index width (32 registers).
REQ-003 Parameter: CNT_W, 16, stall counter width.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 Port: a_reg  input  ADDR_W  requester A destination register.
REQ-008 Port: a_data  input  DATA_W  requester A write data.
REQ-009 Port: a_ready  output  1  requester A granted this cycle.
REQ-010 Port: b_valid  input  1  requester B (load writeback) has a write pending.
REQ-011 Port: b_reg  input  ADDR_W  requester B destination register.
REQ-012 Port: b_data  input  DATA_W  requester B write data.
REQ-013 Port: b_ready  output  1  requester B granted this cycle.
REQ-014 Port: write_register  output  ADDR_W  register file write index, registered.
REQ-015 Port: write_data  output  DATA_W  register file write data, registered.
REQ-016 Port: reg_write  output  1  register file write enable, registered.
REQ-017 Port: stall_count  output  CNT_W  cycles in which a valid requester was not granted.

Function
REQ-018 The block shall grant at most one requester per cycle; a_ready and b_ready are never both 1.
REQ-019 Transfer occurs when x_valid && x_ready on a rising edge; requesters hold valid, reg and data stable until transfer.
REQ-020 Only one valid: that requester is granted in the same cycle (combinational ready), regardless of priority pointer.
REQ-021 Both valid: the requester selected by the 1-bit priority pointer (0 = A, 1 = B) is granted.
REQ-022 After any transfer the pointer shall point to the non-granted requester; with no transfer the pointer holds.
REQ-023 Neither valid: both readies 0, pointer unchanged.
REQ-024 Latency: a transfer in cycle N drives write_register/write_data with the granted reg/data and reg_write=1 in cycle N+1.
REQ-025 No transfer in cycle N: reg_write=0 in cycle N+1; write_register/write_data hold their previous values.
REQ-026 Transfer with destination register 0: handshake completes and pointer updates, but reg_write=0 in N+1 (x0 is never written).
REQ-027 stall_count increments by 1 in each cycle where a valid requester is not granted (both valid); saturates at 2^CNT_W-1, no wrap.
REQ-028 Both requesters valid with the same destination register: handled as normal arbitration; the later-granted value lands one write later, last writer wins.

Reset
REQ-029 While rst=1 at a rising edge: reg_write=0, write_register=0, write_data=0, pointer=0 (A), stall_count=0.
REQ-030 While rst=1, a_ready=0 and b_ready=0; no transfer is accepted in a reset cycle.
REQ-031 Reset asserted mid-operation discards any pending grant; the first cycle after rst deasserts behaves as post-reset with pointer=A.

Verification
REQ-032 Reset: rst=1 two cycles with a_valid=b_valid=1 -> both readies 0, reg_write=0, stall_count=0, outputs 0.
REQ-033 Single requester: a_valid=1, a_reg=5, a_data=64'h0000_0000_DEAD_BEEF -> a_ready=1 same cycle; next cycle reg_write=1, write_register=5, write_data=64'hDEAD_BEEF.
REQ-034 Contention: a_valid=b_valid=1 held for 4 cycles after reset (A reg 3, B reg 7) -> grants A,B,A,B; writes to 3,7,3,7 one cycle later; stall_count=4.
REQ-035 Zero register: b_valid=1, b_reg=0, b_data=64'h1 -> b_ready=1, next cycle reg_write=0; pointer moves to A.
REQ-036 Saturation: CNT_W=4, both valid for 20 cycles -> stall_count stops at 15.
REQ-037 Reset mid-stream: rst=1 during alternating contention -> next post-reset contention cycle grants A first, stall_count restarts at 0.
